decode_stage: RTL and testbench

- Parametrised ID stage for the 16-bit pipelined core.
- Contains the register file, with optional WB-to-ID write-through bypass, and immediate sign-extension.
- Detects load-use hazards, registers the ID/EX pipeline stage with stall/flush handling, and latches halt and the OUT port.
- Control decode comes from the existing controller; this block consumes its flags and registers the control word.

---
 rtl/decode_stage.sv | 102 ++++++++++
 tb/tb_decode_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: ID stage with register file, immediate extension, load-use stall, ID/EX register, halt and OUT latch
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8,
  parameter int ADR_W  = 3,
  parameter int IMM_W  = 8,
  parameter int CTRL_W = 12,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  input  logic [15:0]       inst_id,
  input  logic [DATA_W-1:0] pcinc_id,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              reads_a,
  input  logic              reads_b,
  input  logic              writes_reg,
  input  logic              is_load,
  input  logic              is_halt_in,
  input  logic              is_out_in,
  input  logic              wadr_sel,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              wb_en,
  input  logic [ADR_W-1:0]  wb_adr,
  input  logic [DATA_W-1:0] wb_dat,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [3:0]        ex_d,
  output logic [ADR_W-1:0]  ex_wadr,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_pcinc,
  output logic              ex_is_load,
  output logic              ex_writes,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_en,
  output logic              halted
);
  logic [DATA_W-1:0] rf [REG_N];
  logic [ADR_W-1:0] ra, rb;
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic load_use, accept, unused_ok;
  assign ra = inst_id[13 -: ADR_W];
  assign rb = inst_id[10 -: ADR_W];
  assign unused_ok = ^inst_id;
  assign rd1 = (BYPASS != 0 && wb_en && wb_adr == ra) ? wb_dat : rf[ra];
  assign rd2 = (BYPASS != 0 && wb_en && wb_adr == rb) ? wb_dat : rf[rb];
  for (genvar g = 0; g < DATA_W; g++) begin : g_imm
    if (g < IMM_W) begin : g_fld
      assign imm[g] = inst_id[g];
    end else begin : g_sgn
      assign imm[g] = inst_id[IMM_W-1];
    end
  end
  assign load_use = inst_valid & ex_valid & ex_is_load & ex_writes &
                    ((reads_a & (ra == ex_wadr)) | (reads_b & (rb == ex_wadr)));
  assign stall_out = (load_use | ~ex_ready | halted) & ~flush;
  assign accept = inst_valid & ~flush & ex_ready & ~load_use & ~halted;
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    else if (wb_en)
      rf[wb_adr] <= wb_dat;
  always_ff @(posedge clk)
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      ex_d       <= '0;
      ex_wadr    <= '0;
      ex_ctrl    <= '0;
      ex_pcinc   <= '0;
      ex_is_load <= 1'b0;
      ex_writes  <= 1'b0;
      out_dat    <= '0;
      out_en     <= 1'b0;
      halted     <= 1'b0;
    end else begin
      if (flush) ex_valid <= 1'b0;
      else if (ex_ready && load_use) ex_valid <= 1'b0;
      else if (ex_ready) begin
        ex_valid   <= accept;
        ex_rd1     <= rd1;
        ex_rd2     <= rd2;
        ex_imm     <= imm;
        ex_d       <= inst_id[3:0];
        ex_wadr    <= wadr_sel ? ra : rb;
        ex_ctrl    <= ctrl_in;
        ex_pcinc   <= pcinc_id;
        ex_is_load <= is_load;
        ex_writes  <= writes_reg;
      end
      halted <= halted | (accept & is_halt_in);
      out_en <= accept & is_out_in;
      if (accept && is_out_in) out_dat <= rd1;
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench with a behavioural ID-stage model, checking a bypass and a no-bypass instance
module tb_decode_stage;
  logic clk = 1'b0, reset = 1'b1;
  logic inst_valid = 0, reads_a = 0, reads_b = 0, writes_reg = 0, is_load = 0;
  logic is_halt_in = 0, is_out_in = 0, wadr_sel = 0, flush = 0, ex_ready = 1, wb_en = 0;
  logic [15:0] inst_id = 0, pcinc_id = 0, wb_dat = 0;
  logic [11:0] ctrl_in = 0;
  logic [2:0] wb_adr = 0;
  logic stall_out [2], ex_valid [2], ex_is_load [2], ex_writes [2], out_en [2], halted [2];
  logic [15:0] ex_rd1 [2], ex_rd2 [2], ex_imm [2], ex_pcinc [2], out_dat [2];
  logic [3:0] ex_d [2];
  logic [2:0] ex_wadr [2];
  logic [11:0] ex_ctrl [2];
  int checks = 0, failures = 0;
  bit go = 0;
  always #5 clk = ~clk;
  for (genvar b = 0; b < 2; b++) begin : g_dut
    decode_stage #(.BYPASS(b)) dut (
      .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_id(inst_id), .pcinc_id(pcinc_id),
      .ctrl_in(ctrl_in), .reads_a(reads_a), .reads_b(reads_b), .writes_reg(writes_reg),
      .is_load(is_load), .is_halt_in(is_halt_in), .is_out_in(is_out_in), .wadr_sel(wadr_sel),
      .flush(flush), .ex_ready(ex_ready), .wb_en(wb_en), .wb_adr(wb_adr), .wb_dat(wb_dat),
      .stall_out(stall_out[b]), .ex_valid(ex_valid[b]), .ex_rd1(ex_rd1[b]), .ex_rd2(ex_rd2[b]),
      .ex_imm(ex_imm[b]), .ex_d(ex_d[b]), .ex_wadr(ex_wadr[b]), .ex_ctrl(ex_ctrl[b]),
      .ex_pcinc(ex_pcinc[b]), .ex_is_load(ex_is_load[b]), .ex_writes(ex_writes[b]),
      .out_dat(out_dat[b]), .out_en(out_en[b]), .halted(halted[b]));
  end
  // behavioural model: register array plus the expected ID/EX contents
  logic [15:0] mr [8];
  logic m_valid, m_load, m_wr, m_out_en, m_halted;
  logic [15:0] m_rd1 [2], m_rd2 [2], m_out [2], m_imm, m_pc;
  logic [3:0] m_d;
  logic [2:0] m_wadr;
  logic [11:0] m_ctrl;
  logic [2:0] fa, fb;
  logic lu, stall, acc;
  logic [15:0] ra_v [2], rb_v [2];
  always_comb begin
    fa = inst_id[13:11];
    fb = inst_id[10:8];
    lu = inst_valid && m_valid && m_load && m_wr && ((reads_a && fa == m_wadr) || (reads_b && fb == m_wadr));
    stall = (lu || !ex_ready || m_halted) && !flush;
    acc = inst_valid && !flush && ex_ready && !lu && !m_halted;
    ra_v[0] = mr[fa];
    rb_v[0] = mr[fb];
    ra_v[1] = (wb_en && wb_adr == fa) ? wb_dat : mr[fa];
    rb_v[1] = (wb_en && wb_adr == fb) ? wb_dat : mr[fb];
  end
  always @(posedge clk)
    if (reset) begin
      for (int i = 0; i < 8; i++) mr[i] <= 0;
      m_valid <= 0; m_load <= 0; m_wr <= 0; m_out_en <= 0; m_halted <= 0;
      m_rd1[0] <= 0; m_rd1[1] <= 0; m_rd2[0] <= 0; m_rd2[1] <= 0;
      m_out[0] <= 0; m_out[1] <= 0; m_imm <= 0; m_pc <= 0; m_d <= 0; m_wadr <= 0; m_ctrl <= 0;
    end else begin
      if (wb_en) mr[wb_adr] <= wb_dat;
      if (flush || (ex_ready && lu)) m_valid <= 0;
      else if (ex_ready) begin
        m_valid <= acc;
        m_rd1[0] <= ra_v[0]; m_rd1[1] <= ra_v[1];
        m_rd2[0] <= rb_v[0]; m_rd2[1] <= rb_v[1];
        m_imm <= 16'($signed(inst_id[7:0]));
        m_d <= inst_id[3:0];
        m_wadr <= wadr_sel ? fa : fb;
        m_ctrl <= ctrl_in; m_pc <= pcinc_id; m_load <= is_load; m_wr <= writes_reg;
      end
      if (acc && is_halt_in) m_halted <= 1;
      m_out_en <= acc && is_out_in;
      if (acc && is_out_in) begin
        m_out[0] <= ra_v[0];
        m_out[1] <= ra_v[1];
      end
    end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk)
    if (go)
      for (int b = 0; b < 2; b++) begin
        chk($sformatf("stall_out[%0d]", b), 32'(stall_out[b]), 32'(stall));
        chk($sformatf("ex_valid[%0d]", b), 32'(ex_valid[b]), 32'(m_valid));
        chk($sformatf("halted[%0d]", b), 32'(halted[b]), 32'(m_halted));
        chk($sformatf("out_en[%0d]", b), 32'(out_en[b]), 32'(m_out_en));
        chk($sformatf("out_dat[%0d]", b), 32'(out_dat[b]), 32'(m_out[b]));
        if (m_valid) begin
          chk($sformatf("ex_rd1[%0d]", b), 32'(ex_rd1[b]), 32'(m_rd1[b]));
          chk($sformatf("ex_rd2[%0d]", b), 32'(ex_rd2[b]), 32'(m_rd2[b]));
          chk($sformatf("ex_imm[%0d]", b), 32'(ex_imm[b]), 32'(m_imm));
          chk($sformatf("ex_d[%0d]", b), 32'(ex_d[b]), 32'(m_d));
          chk($sformatf("ex_wadr[%0d]", b), 32'(ex_wadr[b]), 32'(m_wadr));
          chk($sformatf("ex_ctrl[%0d]", b), 32'(ex_ctrl[b]), 32'(m_ctrl));
          chk($sformatf("ex_pcinc[%0d]", b), 32'(ex_pcinc[b]), 32'(m_pc));
          chk($sformatf("ex_is_load[%0d]", b), 32'(ex_is_load[b]), 32'(m_load));
          chk($sformatf("ex_writes[%0d]", b), 32'(ex_writes[b]), 32'(m_wr));
        end
      end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] mk(input logic [2:0] a, input logic [2:0] b, input logic [7:0] imm);
    return {2'b00, a, b, imm};
  endfunction
  task automatic ins(input logic [15:0] i, input logic ua, input logic ub, input logic wr,
                     input logic ld, input logic ht, input logic ot, input logic ws);
    inst_valid = 1; inst_id = i; reads_a = ua; reads_b = ub; writes_reg = wr;
    is_load = ld; is_halt_in = ht; is_out_in = ot; wadr_sel = ws;
    pcinc_id = pcinc_id + 16'd1;
    ctrl_in = 12'($urandom);
  endtask
  task automatic nop();
    inst_valid = 0; reads_a = 0; reads_b = 0; writes_reg = 0; is_load = 0;
    is_halt_in = 0; is_out_in = 0;
  endtask
  initial begin
    tick(); tick();
    reset = 0;
    go = 1;
    chk("reset ex_valid", 32'(ex_valid[1]), 0);
    chk("reset ex_imm", 32'(ex_imm[1]), 0);
    chk("reset ex_ctrl", 32'(ex_ctrl[1]), 0);
    chk("reset out_dat", 32'(out_dat[1]), 0);
    chk("reset halted", 32'(halted[1]), 0);
    wb_en = 1; wb_adr = 3; wb_dat = 16'h1234;
    ins(mk(3, 0, 8'hF0), 1, 0, 1, 0, 0, 0, 1);
    tick();
    wb_en = 0;
    chk("bypass rd1", 32'(ex_rd1[1]), 32'h1234);
    chk("nobypass rd1", 32'(ex_rd1[0]), 32'h0000);
    chk("imm F0", 32'(ex_imm[1]), 32'hFFF0);
    chk("wadr ra", 32'(ex_wadr[1]), 3);
    ins(mk(3, 1, 8'h7F), 1, 1, 0, 0, 0, 0, 0);
    tick();
    chk("imm 7F", 32'(ex_imm[1]), 32'h007F);
    chk("nobypass later", 32'(ex_rd1[0]), 32'h1234);
    ins(mk(0, 2, 8'h05), 0, 0, 1, 1, 0, 0, 0);
    tick();
    chk("load wadr", 32'(ex_wadr[1]), 2);
    ins(mk(1, 2, 8'h22), 0, 1, 1, 0, 0, 0, 0);
    #1 chk("lu stall", 32'(stall_out[1]), 1);
    tick();
    chk("lu bubble", 32'(ex_valid[1]), 0);
    chk("lu stall gone", 32'(stall_out[1]), 0);
    tick();
    chk("lu accept", 32'(ex_valid[1]), 1);
    chk("lu imm", 32'(ex_imm[1]), 32'h0022);
    ins(mk(4, 5, 8'h11), 1, 1, 1, 0, 0, 0, 0);
    ex_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold imm", 32'(ex_imm[1]), 32'h0022);
      chk("hold stall", 32'(stall_out[1]), 1);
    end
    ex_ready = 1;
    tick();
    chk("ready load", 32'(ex_imm[1]), 32'h0011);
    ins(mk(0, 6, 8'h00), 0, 0, 1, 1, 0, 0, 0);
    tick();
    ins(mk(6, 1, 8'h33), 1, 0, 1, 0, 0, 0, 0);
    flush = 1;
    #1 chk("flush lu stall", 32'(stall_out[1]), 0);
    tick();
    flush = 0;
    chk("flush lu valid", 32'(ex_valid[1]), 0);
    nop();
    wb_en = 1; wb_adr = 5; wb_dat = 16'hBEEF;
    tick();
    wb_en = 0;
    ins(mk(5, 0, 8'h00), 1, 0, 0, 0, 0, 1, 0);
    tick();
    chk("out_en pulse", 32'(out_en[1]), 1);
    chk("out_dat", 32'(out_dat[1]), 32'hBEEF);
    nop();
    tick();
    chk("out_en drop", 32'(out_en[1]), 0);
    chk("out_dat hold", 32'(out_dat[0]), 32'hBEEF);
    ins(mk(0, 0, 8'h00), 0, 0, 0, 0, 1, 0, 0);
    flush = 1;
    tick();
    flush = 0;
    chk("halt flushed", 32'(halted[1]), 0);
    tick();
    chk("halt set", 32'(halted[1]), 1);
    chk("halt stall", 32'(stall_out[1]), 1);
    ins(mk(2, 3, 8'h44), 1, 1, 1, 0, 0, 0, 0);
    tick(); tick();
    chk("halt blocks", 32'(ex_valid[1]), 0);
    reset = 1;
    tick();
    reset = 0;
    chk("rst halted", 32'(halted[1]), 0);
    chk("rst out_dat", 32'(out_dat[1]), 0);
    ins(mk(5, 3, 8'h01), 1, 1, 1, 0, 0, 0, 0);
    tick();
    chk("rst r5", 32'(ex_rd1[1]), 0);
    chk("rst r3", 32'(ex_rd2[1]), 0);
    nop();
    tick();
    go = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
